intr_ctrl: RTL and testbench

- Machine-mode interrupt controller between the interrupt sources and the trap controller.
- Synchronizes the asynchronous external interrupt line and maintains the mip pending bits.
- Masks pending bits with mie/mstatus.MIE and arbitrates by fixed priority.
- Issues one registered, held request per interrupt to the trap controller via a req/ack handshake, then blocks further requests until mret.

---
 rtl/intr_ctrl_pkg.sv | 41 ++++
 rtl/intr_ctrl_if.sv | 24 ++
 rtl/intr_ctrl_cdc_sync.sv | 23 ++
 rtl/intr_ctrl.sv | 95 +++++++++
 tb/tb_intr_ctrl.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the machine-mode interrupt controller: mcause codes,
// FSM encodings, the per-source bit vector and the fixed-priority helpers.
package intr_ctrl_pkg;

  localparam int SYNC_STAGES_DEFAULT = 2;

  localparam logic [3:0] CODE_NONE = 4'd0;
  localparam logic [3:0] CODE_MSI  = 4'd3;
  localparam logic [3:0] CODE_MTI  = 4'd7;
  localparam logic [3:0] CODE_MEI  = 4'd11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;

  // Bit order matches priority: mei is the MSB and wins.
  typedef struct packed {
    logic mei;
    logic msi;
    logic mti;
  } irq_vec_t;

  function automatic irq_vec_t pick_highest(input irq_vec_t elig);
    irq_vec_t sel;
    sel = '0;
    if (elig.mei)      sel.mei = 1'b1;
    else if (elig.msi) sel.msi = 1'b1;
    else if (elig.mti) sel.mti = 1'b1;
    return sel;
  endfunction

  function automatic logic [3:0] code_of(input irq_vec_t sel);
    logic [3:0] code;
    code = CODE_NONE;
    if (sel.mei)      code = CODE_MEI;
    else if (sel.msi) code = CODE_MSI;
    else if (sel.mti) code = CODE_MTI;
    return code;
  endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// Request/acknowledge channel between the interrupt controller (master)
// and the trap controller (slave).
interface intr_ctrl_if;
  logic       irq_req;
  logic       irq_ack;
  logic       mret;
  logic       external_interrupt;
  logic       software_interrupt;
  logic       timer_interrupt;
  logic [3:0] irq_code;
  logic       in_handler;

  modport master (
    output irq_req, external_interrupt, software_interrupt, timer_interrupt,
           irq_code, in_handler,
    input  irq_ack, mret
  );

  modport slave (
    input  irq_req, external_interrupt, software_interrupt, timer_interrupt,
           irq_code, in_handler,
    output irq_ack, mret
  );
endinterface

// File: rtl/intr_ctrl_cdc_sync.sv
// N-flop single-bit synchronizer with asynchronous active-low reset.
// STAGES must be at least 2.
module cdc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync;

  // NOTE: flops are written with <= so every stage samples the previous
  // stage's old value; blocking = here would collapse the chain to one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[STAGES-2:0], d};
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/intr_ctrl.sv
// Machine-mode interrupt controller: syncs and registers the mip bits, masks
// and prioritises them, and holds one request per interrupt until ack/withdraw.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_irq_async,
  input  logic        sw_irq,
  input  logic        timer_irq,
  input  logic        i_mstatus_mie,
  input  logic        i_mie_meie,
  input  logic        i_mie_msie,
  input  logic        i_mie_mtie,
  intr_ctrl_if.master trap,
  output logic        o_mip_meip,
  output logic        o_mip_msip,
  output logic        o_mip_mtip
);

  logic       ext_sync;
  logic [1:0] state;
  irq_vec_t   mip, enable, eligible, sel, latched;
  logic       still_eligible;

  cdc_sync #(.STAGES(SYNC_STAGES)) u_ext_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (ext_irq_async),
    .q     (ext_sync)
  );

  // Pending bits are plain levels: they follow their sources, never sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_mip_meip <= 1'b0;
      o_mip_msip <= 1'b0;
      o_mip_mtip <= 1'b0;
    end else begin
      o_mip_meip <= ext_sync;
      o_mip_msip <= sw_irq;
      o_mip_mtip <= timer_irq;
    end
  end

  assign mip            = {o_mip_meip, o_mip_msip, o_mip_mtip};
  assign enable         = {i_mie_meie, i_mie_msie, i_mie_mtie};
  assign eligible       = mip & enable & {3{i_mstatus_mie}};
  assign sel            = pick_highest(eligible);
  assign still_eligible = |(latched & eligible);

  // latched is non-zero only in REQ, so the cause outputs double as "valid".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      latched <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|eligible) begin
            state   <= ST_REQ;
            latched <= sel;
          end
        end
        ST_REQ: begin
          // Ack takes precedence over a same-cycle withdraw.
          if (trap.irq_ack) begin
            state   <= ST_BUSY;
            latched <= '0;
          end else if (!still_eligible) begin
            state   <= ST_IDLE;
            latched <= '0;
          end
        end
        ST_BUSY: begin
          if (trap.mret) state <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          latched <= '0;
        end
      endcase
    end
  end

  assign trap.irq_req            = (state == ST_REQ);
  assign trap.in_handler         = (state == ST_BUSY);
  assign trap.external_interrupt = latched.mei;
  assign trap.software_interrupt = latched.msi;
  assign trap.timer_interrupt    = latched.mti;
  assign trap.irq_code           = code_of(latched);

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl: reset, priority/freeze,
// withdraw, ack-vs-withdraw, masking and asynchronous reset mid-handler.
module tb_intr_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ext_irq_async = 1'b1;
  logic sw_irq = 1'b1;
  logic timer_irq = 1'b1;
  logic i_mstatus_mie = 1'b1;
  logic i_mie_meie = 1'b1;
  logic i_mie_msie = 1'b1;
  logic i_mie_mtie = 1'b1;
  logic o_mip_meip, o_mip_msip, o_mip_mtip;

  int checks = 0;
  int failures = 0;

  // {irq_req, ext, sw, timer, irq_code[3:0], in_handler}
  localparam logic [8:0] O_IDLE = 9'b0_000_0000_0;
  localparam logic [8:0] O_BUSY = 9'b0_000_0000_1;
  localparam logic [8:0] O_MEI  = 9'b1_100_1011_0;
  localparam logic [8:0] O_MSI  = 9'b1_010_0011_0;
  localparam logic [8:0] O_MTI  = 9'b1_001_0111_0;

  always #5 clk = ~clk;

  intr_ctrl_if bus ();

  intr_ctrl #(.SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .ext_irq_async (ext_irq_async),
    .sw_irq        (sw_irq),
    .timer_irq     (timer_irq),
    .i_mstatus_mie (i_mstatus_mie),
    .i_mie_meie    (i_mie_meie),
    .i_mie_msie    (i_mie_msie),
    .i_mie_mtie    (i_mie_mtie),
    .trap          (bus),
    .o_mip_meip    (o_mip_meip),
    .o_mip_msip    (o_mip_msip),
    .o_mip_mtip    (o_mip_mtip)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {bus.irq_req, bus.external_interrupt, bus.software_interrupt,
            bus.timer_interrupt, bus.irq_code, bus.in_handler};
  endfunction

  function automatic logic [2:0] mips();
    return {o_mip_meip, o_mip_msip, o_mip_mtip};
  endfunction

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.irq_ack = 1'b0;
    bus.mret    = 1'b0;

    // 1. Reset with all sources high, then release with only ext pending.
    step(3);
    check("rst_outs", outs(), O_IDLE);
    check("rst_mip", mips(), 3'b000);
    sw_irq = 1'b0; timer_irq = 1'b0; rst = 1'b1;
    step(3);
    check("rst_lat_early", outs(), O_IDLE);
    check("rst_meip", mips(), 3'b100);
    step(1);
    check("rst_lat_mei", outs(), O_MEI);
    bus.irq_ack = 1'b1; step(1); bus.irq_ack = 1'b0;
    check("rst_ack_busy", outs(), O_BUSY);
    ext_irq_async = 1'b0; step(4);
    check("busy_mip_clear", mips(), 3'b000);
    bus.mret = 1'b1; step(1); bus.mret = 1'b0; step(1);
    check("rst_idle_after_mret", outs(), O_IDLE);

    // 2. Priority at latch time, then frozen while a higher source rises.
    timer_irq = 1'b1; step(1);
    check("t2_mtip_only", {mips(), bus.irq_req}, 4'b0010);
    sw_irq = 1'b1; step(1);
    check("t2_latch_mti", outs(), O_MTI);
    ext_irq_async = 1'b1; step(6);
    check("t2_frozen", outs(), O_MTI);
    check("t2_all_pending", mips(), 3'b111);
    bus.irq_ack = 1'b1; step(1); bus.irq_ack = 1'b0;
    check("t2_busy", outs(), O_BUSY);
    step(3);
    check("t2_no_nest", outs(), O_BUSY);
    bus.mret = 1'b1; step(1); bus.mret = 1'b0;
    check("t2_mret_idle", outs(), O_IDLE);
    step(1);
    check("t2_mei_after_mret", outs(), O_MEI);
    bus.irq_ack = 1'b1; step(1); bus.irq_ack = 1'b0;
    ext_irq_async = 1'b0; sw_irq = 1'b0; timer_irq = 1'b0; step(5);
    bus.mret = 1'b1; step(1); bus.mret = 1'b0; step(1);
    check("t2_clean", outs(), O_IDLE);

    // 3. Withdraw by source drop, then by global disable.
    sw_irq = 1'b1; step(2);
    check("t3_msi", outs(), O_MSI);
    sw_irq = 1'b0; step(1);
    check("t3_hold", outs(), O_MSI);
    step(1);
    check("t3_withdraw", outs(), O_IDLE);
    bus.irq_ack = 1'b1; step(1); bus.irq_ack = 1'b0;
    check("t3_ack_ignored", outs(), O_IDLE);
    sw_irq = 1'b1; step(2);
    check("t3b_msi", outs(), O_MSI);
    i_mstatus_mie = 1'b0; step(2);
    check("t3b_withdraw", outs(), O_IDLE);
    check("t3b_mip_still", mips(), 3'b010);
    sw_irq = 1'b0; step(2); i_mstatus_mie = 1'b1;
    bus.mret = 1'b1; step(1); bus.mret = 1'b0;
    check("t3_mret_idle_ignored", outs(), O_IDLE);

    // 4. mret ignored in REQ; ack and mask-clear in the same cycle.
    timer_irq = 1'b1; step(2);
    check("t4_mti", outs(), O_MTI);
    bus.mret = 1'b1; step(1); bus.mret = 1'b0;
    check("t4_mret_in_req", outs(), O_MTI);
    bus.irq_ack = 1'b1; i_mie_mtie = 1'b0; step(1);
    bus.irq_ack = 1'b0; i_mie_mtie = 1'b1;
    check("t4_ack_wins", outs(), O_BUSY);
    step(10);
    check("t4_no_rereq", outs(), O_BUSY);
    bus.mret = 1'b1; step(1); bus.mret = 1'b0; step(1);
    check("t4_rereq", outs(), O_MTI);

    // 5. Pending but masked for 20 cycles, then unmasked.
    bus.irq_ack = 1'b1; step(1); bus.irq_ack = 1'b0;
    i_mie_mtie = 1'b0; bus.mret = 1'b1; step(1); bus.mret = 1'b0;
    check("t5_idle", outs(), O_IDLE);
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("t5_masked", {bus.irq_req, o_mip_mtip}, 2'b01);
    end
    i_mie_mtie = 1'b1; step(1);
    check("t5_unmask", outs(), O_MTI);

    // 6. Half-cycle asynchronous reset pulse while BUSY.
    bus.irq_ack = 1'b1; step(1); bus.irq_ack = 1'b0;
    check("t6_busy", outs(), O_BUSY);
    #1 rst = 1'b0;
    #1 check("t6_async_outs", outs(), O_IDLE);
    check("t6_async_mip", mips(), 3'b000);
    #4 rst = 1'b1;
    step(1);
    check("t6_after_release", {outs(), mips()}, {O_IDLE, 3'b000});
    step(1);
    check("t6_mtip", {mips(), bus.irq_req}, 4'b0010);
    step(1);
    check("t6_rereq", outs(), O_MTI);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
